// File: rtl/miniRISC_pkg.sv
// Shared KGP-miniRISC definitions: arbiter state codes, ALU control codes and
// the default datapath widths used by the ALU-facing blocks.
package miniRISC_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SHAMT_W = 5;
    localparam int DEF_OP_W    = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and under
// contention the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (requester 0) and the
// branch/address unit (requester 1), returning results on per-owner channels.
module alu_arbiter
    import miniRISC_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int OP_W    = DEF_OP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               r0_valid,
    output logic               r0_ready,
    input  logic [OP_W-1:0]    r0_op,
    input  logic [DATA_W-1:0]  r0_a,
    input  logic [DATA_W-1:0]  r0_b,
    input  logic [SHAMT_W-1:0] r0_shamt,
    input  logic               r1_valid,
    output logic               r1_ready,
    input  logic [OP_W-1:0]    r1_op,
    input  logic [DATA_W-1:0]  r1_a,
    input  logic [DATA_W-1:0]  r1_b,
    input  logic [SHAMT_W-1:0] r1_shamt,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_negative,
    output logic               rsp_zero,
    output logic               rsp_carry,
    output logic               busy,
    output logic [DATA_W-1:0]  alu_input1,
    output logic [DATA_W-1:0]  alu_input2,
    output logic [SHAMT_W-1:0] alu_shamt,
    output logic [OP_W-1:0]    alu_control_signal,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_negative,
    input  logic               alu_zero,
    input  logic               alu_carry
);

    logic [1:0]         state_q, state_d;
    logic               owner_q;
    logic               lastGrant_q;
    logic [OP_W-1:0]    op_q;
    logic [DATA_W-1:0]  a_q, b_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [DATA_W-1:0]  result_q;
    logic               negative_q, zero_q, carry_q;

    logic [1:0] reqValid, grant, reqReady;
    logic       accept, respDone;

    assign reqValid = {r1_valid, r0_valid};

    rr_arb2 u_arb (
        .valid_i      (reqValid),
        .last_grant_i (lastGrant_q),
        .grant_o      (grant)
    );

    // Ready is gated by rst_n so no request appears accepted while held in reset.
    assign reqReady = (state_q == ST_IDLE && rst_n) ? grant : 2'b00;
    assign accept   = |(reqValid & reqReady);
    assign respDone = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (respDone) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset leaves lastGrant at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            shamt_q     <= '0;
            owner_q     <= 1'b0;
            lastGrant_q <= 1'b1;
        end else if (accept) begin
            op_q        <= grant[1] ? r1_op    : r0_op;
            a_q         <= grant[1] ? r1_a     : r0_a;
            b_q         <= grant[1] ? r1_b     : r0_b;
            shamt_q     <= grant[1] ? r1_shamt : r0_shamt;
            owner_q     <= grant[1];
            lastGrant_q <= grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            negative_q <= 1'b0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            result_q   <= alu_out;
            negative_q <= alu_negative;
            zero_q     <= alu_zero;
            carry_q    <= alu_carry;
        end
    end

    assign r0_ready           = reqReady[0];
    assign r1_ready           = reqReady[1];
    assign rsp0_valid         = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid         = (state_q == ST_RESP) && owner_q;
    assign rsp_result         = result_q;
    assign rsp_negative       = negative_q;
    assign rsp_zero           = zero_q;
    assign rsp_carry          = carry_q;
    assign busy               = (state_q != ST_IDLE);
    assign alu_input1         = a_q;
    assign alu_input2         = b_q;
    assign alu_shamt          = shamt_q;
    assign alu_control_signal = op_q;

endmodule
